pipe_stall_ctrl: RTL and testbench



---
 rtl/pipe_stall_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline control responder: turns hazard, branch, memory-busy and HLT inputs into
// per-stage write-enable/flush/bubble controls, sequences halt drain, counts stalls/flushes.
module pipe_stall_ctrl #(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             br_taken,
    input  logic             hlt_id,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_bubble,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             memwb_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned DRN_W = (DRAIN_CYCLES > 4) ? $clog2(DRAIN_CYCLES) : 2;
    localparam logic [DRN_W-1:0] DRN_INIT = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [DRN_W-1:0] drn_q, drn_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             stall_inc;
    logic             flush_inc;

    // Next state, drain sequencing and zero-latency stage controls
    always_comb begin
        state_d      = state_q;
        drn_d        = drn_q;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        ifid_flush   = 1'b0;
        idex_we      = 1'b0;
        idex_bubble  = 1'b0;
        exmem_we     = 1'b0;
        memwb_we     = 1'b0;
        memwb_bubble = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (dmem_busy) begin
                    memwb_we     = 1'b1;
                    memwb_bubble = 1'b1;
                    stall_inc    = 1'b1;
                end else if (stall) begin
                    idex_we     = 1'b1;
                    idex_bubble = 1'b1;
                    exmem_we    = 1'b1;
                    memwb_we    = 1'b1;
                    stall_inc   = 1'b1;
                end else if (hlt_id) begin
                    ifid_we    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_we    = 1'b1;
                    exmem_we   = 1'b1;
                    memwb_we   = 1'b1;
                    stall_inc  = 1'b1;
                    state_d    = ST_DRAIN;
                    drn_d      = DRN_INIT;
                end else if (br_taken) begin
                    pc_we      = 1'b1;
                    ifid_we    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_we    = 1'b1;
                    exmem_we   = 1'b1;
                    memwb_we   = 1'b1;
                    flush_inc  = 1'b1;
                end else if (imem_busy) begin
                    ifid_we    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_we    = 1'b1;
                    exmem_we   = 1'b1;
                    memwb_we   = 1'b1;
                    stall_inc  = 1'b1;
                end else begin
                    pc_we    = 1'b1;
                    ifid_we  = 1'b1;
                    idex_we  = 1'b1;
                    exmem_we = 1'b1;
                    memwb_we = 1'b1;
                end
            end

            ST_DRAIN: begin
                ifid_flush = 1'b1;
                if (dmem_busy) begin
                    memwb_we     = 1'b1;
                    memwb_bubble = 1'b1;
                end else begin
                    ifid_we  = 1'b1;
                    idex_we  = 1'b1;
                    exmem_we = 1'b1;
                    memwb_we = 1'b1;
                    // drn counts remaining non-frozen drain cycles after this one
                    if (drn_q == '0) begin
                        state_d = ST_HALTED;
                    end else begin
                        drn_d = drn_q - DRN_W'(1);
                    end
                end
            end

            ST_HALTED: begin
                state_d = ST_HALTED;
            end

            default: begin
                state_d = ST_RUN;
                drn_d   = '0;
            end
        endcase

        if (!rst_n) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            ifid_flush   = 1'b0;
            idex_we      = 1'b0;
            idex_bubble  = 1'b0;
            exmem_we     = 1'b0;
            memwb_we     = 1'b0;
            memwb_bubble = 1'b0;
        end
    end

    // Saturating performance counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        halted_d    = (state_d == ST_HALTED);
        if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_inc && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            drn_q       <= '0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drn_q       <= drn_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Registered status is forced low while reset is held
    assign halted    = rst_n & halted_q;
    assign stall_cnt = rst_n ? stall_cnt_q : '0;
    assign flush_cnt = rst_n ? flush_cnt_q : '0;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios plus random stimulus
// against a rule-level reference model; a CNT_W=4 instance exercises saturation.
module tb_pipe_stall_ctrl;

    localparam int unsigned CNT_W        = 16;
    localparam int unsigned SAT_W        = 4;
    localparam int unsigned DRAIN_CYCLES = 3;

    // Control vector order: {pc, ifid_we, ifid_flush, idex_we, idex_bubble, exmem, memwb_we, memwb_bubble}
    localparam logic [7:0] C_QUIET  = 8'hD6;
    localparam logic [7:0] C_FREEZE = 8'h03;
    localparam logic [7:0] C_STALL  = 8'h1E;
    localparam logic [7:0] C_FETCHK = 8'h76;
    localparam logic [7:0] C_BRANCH = 8'hF6;
    localparam logic [7:0] C_DFRZ   = 8'h23;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0, br_taken = 1'b0, hlt_id = 1'b0, imem_busy = 1'b0, dmem_busy = 1'b0;

    logic a_pc_we, a_ifid_we, a_ifid_flush, a_idex_we, a_idex_bubble, a_exmem_we, a_memwb_we, a_memwb_bubble, a_halted;
    logic b_pc_we, b_ifid_we, b_ifid_flush, b_idex_we, b_idex_bubble, b_exmem_we, b_memwb_we, b_memwb_bubble, b_halted;
    logic [CNT_W-1:0] a_stall_cnt, a_flush_cnt;
    logic [SAT_W-1:0] b_stall_cnt, b_flush_cnt;
    logic [7:0] ctrl_a, ctrl_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit m_halted = 1'b0;
    int m_drain  = 0;
    int m_stalls = 0;
    int m_flushes = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN_CYCLES)) u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken), .hlt_id(hlt_id),
        .imem_busy(imem_busy), .dmem_busy(dmem_busy),
        .pc_we(a_pc_we), .ifid_we(a_ifid_we), .ifid_flush(a_ifid_flush), .idex_we(a_idex_we),
        .idex_bubble(a_idex_bubble), .exmem_we(a_exmem_we), .memwb_we(a_memwb_we),
        .memwb_bubble(a_memwb_bubble), .halted(a_halted), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipe_stall_ctrl #(.CNT_W(SAT_W), .DRAIN_CYCLES(DRAIN_CYCLES)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken), .hlt_id(hlt_id),
        .imem_busy(imem_busy), .dmem_busy(dmem_busy),
        .pc_we(b_pc_we), .ifid_we(b_ifid_we), .ifid_flush(b_ifid_flush), .idex_we(b_idex_we),
        .idex_bubble(b_idex_bubble), .exmem_we(b_exmem_we), .memwb_we(b_memwb_we),
        .memwb_bubble(b_memwb_bubble), .halted(b_halted), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    assign ctrl_a = {a_pc_we, a_ifid_we, a_ifid_flush, a_idex_we, a_idex_bubble, a_exmem_we, a_memwb_we, a_memwb_bubble};
    assign ctrl_b = {b_pc_we, b_ifid_we, b_ifid_flush, b_idex_we, b_idex_bubble, b_exmem_we, b_memwb_we, b_memwb_bubble};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int unsigned w);
        int lim;
        lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    // Expected controls from the priority rules and the model's mode
    function automatic logic [7:0] exp_ctrl(input bit rn, input bit st, input bit br,
                                            input bit hl, input bit im, input bit dm);
        if (!rn || m_halted) return 8'h00;
        if (m_drain > 0)     return dm ? C_DFRZ : C_FETCHK;
        if (dm)              return C_FREEZE;
        if (st)              return C_STALL;
        if (hl)              return C_FETCHK;
        if (br)              return C_BRANCH;
        if (im)              return C_FETCHK;
        return C_QUIET;
    endfunction

    // One clock: drive inputs at negedge, check, advance the model past posedge
    task automatic cycle(input bit rn, input bit st, input bit br, input bit hl, input bit im, input bit dm);
        logic [7:0] e;
        rst_n = rn; stall = st; br_taken = br; hlt_id = hl; imem_busy = im; dmem_busy = dm;
        #1;
        e = exp_ctrl(rn, st, br, hl, im, dm);
        check("ctrl", 32'(ctrl_a), 32'(e));
        check("ctrl_sat", 32'(ctrl_b), 32'(e));
        check("halted", 32'(a_halted), 32'(rn && m_halted));
        check("stall_cnt", 32'(a_stall_cnt), rn ? 32'(sat(m_stalls, CNT_W)) : 32'd0);
        check("flush_cnt", 32'(a_flush_cnt), rn ? 32'(sat(m_flushes, CNT_W)) : 32'd0);
        check("stall_cnt_sat", 32'(b_stall_cnt), rn ? 32'(sat(m_stalls, SAT_W)) : 32'd0);
        check("flush_cnt_sat", 32'(b_flush_cnt), rn ? 32'(sat(m_flushes, SAT_W)) : 32'd0);
        @(posedge clk);
        #1;
        if (!rn) begin
            m_halted = 1'b0; m_drain = 0; m_stalls = 0; m_flushes = 0;
        end else if (m_halted) begin
            m_halted = 1'b1;
        end else if (m_drain > 0) begin
            if (!dm) begin
                m_drain--;
                if (m_drain == 0) m_halted = 1'b1;
            end
        end else begin
            if (!e[7]) m_stalls++;
            if (!dm && !st && !hl && br) m_flushes++;
            if (!dm && !st && hl) m_drain = DRAIN_CYCLES;
        end
        @(negedge clk);
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int lat;
        @(negedge clk);

        // Reset with random inputs, then quiet run
        for (int i = 0; i < 2; i++)
            cycle(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        quiet(2);
        check("rst_quiet_ctrl", 32'(ctrl_a), 32'(C_QUIET));

        // Load-use pulse
        cycle(1, 1, 0, 0, 0, 0);
        check("lu_stall_cnt", 32'(a_stall_cnt), 32'd1);

        // Branch alone, then branch masked by load-use
        cycle(1, 0, 1, 0, 0, 0);
        check("br_flush_cnt", 32'(a_flush_cnt), 32'd1);
        cycle(1, 1, 1, 0, 0, 0);
        check("br_stall_flush_cnt", 32'(a_flush_cnt), 32'd1);
        check("br_stall_stall_cnt", 32'(a_stall_cnt), 32'd2);
        quiet(1);

        // dmem freeze with branch from a fresh reset
        cycle(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 0, 1, 0, 0, 1);
        check("frz_stall_cnt", 32'(a_stall_cnt), 32'd5);
        check("frz_flush_cnt", 32'(a_flush_cnt), 32'd0);

        // Halt latency without memory stalls
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 0, 0);
        lat = 1;
        while (!a_halted && lat < 20) begin
            cycle(1, 0, 0, 0, 0, 0);
            lat++;
        end
        check("halt_lat", 32'(lat), 32'd4);
        cycle(1, 1, 1, 1, 1, 0);

        // Halt latency with two frozen drain cycles
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 1);
        lat = 4;
        while (!a_halted && lat < 20) begin
            cycle(1, 0, 0, 0, 0, 0);
            lat++;
        end
        check("halt_lat_frz", 32'(lat), 32'd6);

        // Reset out of HALTED returns to RUN
        cycle(0, 0, 0, 0, 0, 0);
        quiet(1);
        check("halt_rst_ctrl", 32'(ctrl_a), 32'(C_QUIET));

        // Saturation on the narrow instance
        cycle(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0, 1, 0);
        check("sat_stall_cnt", 32'(b_stall_cnt), 32'd15);
        check("wide_stall_cnt", 32'(a_stall_cnt), 32'd20);

        // Random mix with occasional reset
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 29) != 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 4) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
